// File: rtl/concat_byte_packer.sv
// rtl/concat_byte_packer.sv - packs 9-bit {A,B,C} records MSB-first into a byte stream with zero-padded flush
module concat_byte_packer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_a,
  input  logic [2:0]       in_b,
  input  logic [3:0]       in_c,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic [CNT_W-1:0] rec_count,
  output logic [CNT_W-1:0] byte_count
);

  // Left-aligned bit buffer: valid bits live in [15:16-fill], everything below is always 0,
  // which is what makes the flush padding free.
  logic [15:0] buf_q;
  logic [4:0]  fill;
  logic        flush_pending;

  logic [8:0]  rec;
  logic [15:0] rec_ext;
  logic [2:0]  push_shift;
  logic        push;
  logic        pop;

  assign rec     = {in_a, in_b, in_c};
  assign rec_ext = {7'd0, rec};

  // A push only happens with fill <= 7, so fill[2:0] alone gives the alignment shift.
  assign push_shift = 3'd7 - fill[2:0];

  // Handshake flags depend on registered state only; in_ready never looks at out_ready.
  assign in_ready  = (fill <= 5'd7) && !flush_pending;
  assign out_valid = (fill >= 5'd8) || (flush_pending && (fill != 5'd0));
  assign out_data  = buf_q[15:8];
  assign out_last  = out_valid && flush_pending && (fill <= 5'd8);

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Buffer, fill level and counters: push and pop can never coincide, so one if/else covers both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q      <= 16'd0;
      fill       <= 5'd0;
      rec_count  <= '0;
      byte_count <= '0;
    end else if (push) begin
      buf_q     <= buf_q | (rec_ext << push_shift);
      fill      <= fill + 5'd9;
      rec_count <= rec_count + 1'b1;
    end else if (pop) begin
      buf_q      <= buf_q << 8;
      fill       <= (fill >= 5'd8) ? (fill - 5'd8) : 5'd0;
      byte_count <= byte_count + 1'b1;
    end
  end

  // Flush request: clears once an empty buffer is seen; a repeat request while pending is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_pending <= 1'b0;
    end else if (flush_pending && (fill == 5'd0)) begin
      flush_pending <= 1'b0;
    end else if (flush) begin
      flush_pending <= 1'b1;
    end
  end

endmodule
